// File: rtl/mod_memory.sv
// mod_memory -- memory-access stage between execute and writeback.
//
// Accepts one execute bundle per handshake (can_memory while mem_ready),
// performs at most one data-memory load or store over a single-outstanding
// req/ack port, and presents a registered writeback bundle together with a
// one-cycle can_writeback strobe. Non-memory ops take one cycle. Memory ops
// keep the stage busy until mem_ack arrives or the watchdog gives up.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   can_memory / mem_ready execute-side handshake (ready only in IDLE)
//   exmem                  execute bundle (ex_mem_t)
//   mem_req, mem_we,       data-memory request; address, direction and
//   mem_addr_o, mem_wdata  write data are stable while mem_req is high
//   mem_ack, mem_rdata     completion strobe and read data
//   exwb, can_writeback    registered result bundle and its valid pulse
//   store_memstage_active  a store is in flight or completing
//   mem_error              sticky watchdog-expiry flag

typedef struct packed {
  logic [0:63] pc_contents;
  logic [0:63] alu_result;
  logic [0:63] alu_ext_result;
  logic [0:63] mem_addr;
  logic [0:63] store_data;
  logic [0:7]  ctl_opcode;
  logic        twob_opcode;
  logic [0:3]  ctl_regByte;
  logic [0:3]  ctl_rmByte;
  logic        sim_end;
  logic [0:1]  mod;
} ex_mem_t;

typedef struct packed {
  logic [0:63] pc_contents;
  logic [0:63] alu_result;
  logic [0:63] alu_ext_result;
  logic [0:7]  ctl_opcode;
  logic        twob_opcode;
  logic [0:3]  ctl_regByte;
  logic [0:3]  ctl_rmByte;
  logic        sim_end;
  logic [0:1]  mod;
} ex_wb_t;

module mod_memory #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        can_memory,
  output logic        mem_ready,
  input  ex_mem_t     exmem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output ex_wb_t      exwb,
  output logic        can_writeback,
  output logic        store_memstage_active,
  output logic        mem_error
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  ex_wb_t           bundle_q, bundle_d;   // bundle held while the access runs
  ex_wb_t           exwb_q, exwb_d;       // result presented to writeback
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             load_q, load_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             is_load_in;
  logic             is_store_in;

  // Writeback fields are a straight copy of the execute bundle; the memory
  // address and store data are consumed here and not forwarded.
  function automatic ex_wb_t to_exwb(input ex_mem_t b);
    ex_wb_t w;
    w.pc_contents    = b.pc_contents;
    w.alu_result     = b.alu_result;
    w.alu_ext_result = b.alu_ext_result;
    w.ctl_opcode     = b.ctl_opcode;
    w.twob_opcode    = b.twob_opcode;
    w.ctl_regByte    = b.ctl_regByte;
    w.ctl_rmByte     = b.ctl_rmByte;
    w.sim_end        = b.sim_end;
    w.mod            = b.mod;
    return w;
  endfunction

  // Opcode classification. Two-byte opcodes never touch memory here, and
  // mod==3 on MOV (137/139) is the register-to-register form. LEA (141)
  // falls through to pass because it only computes an address.
  always_comb begin
    is_load_in  = 1'b0;
    is_store_in = 1'b0;
    if (!exmem.twob_opcode) begin
      is_load_in  = ((exmem.ctl_opcode == 8'd139) && (exmem.mod != 2'd3)) ||
                    ((exmem.ctl_opcode >= 8'd88) && (exmem.ctl_opcode <= 8'd95)) ||
                    (exmem.ctl_opcode == 8'd195);
      is_store_in = ((exmem.ctl_opcode == 8'd137) && (exmem.mod != 2'd3)) ||
                    ((exmem.ctl_opcode >= 8'd80) && (exmem.ctl_opcode <= 8'd87)) ||
                    (exmem.ctl_opcode == 8'd232) ||
                    (exmem.ctl_opcode == 8'd255);
    end
  end

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    exwb_d   = exwb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    load_d   = load_q;
    store_d  = store_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (can_memory) begin
          bundle_d = to_exwb(exmem);
          addr_d   = exmem.mem_addr;
          wdata_d  = exmem.store_data;
          load_d   = is_load_in;
          store_d  = is_store_in;
          cnt_d    = '0;
          if (is_load_in || is_store_in) begin
            state_d = ST_ACCESS;
          end else begin
            // Pass-through: result register loads now so it is valid in DONE.
            exwb_d  = to_exwb(exmem);
            state_d = ST_DONE;
          end
        end
      end

      ST_ACCESS: begin
        // Ack is tested first so an ack on the final watchdog cycle wins.
        if (mem_ack) begin
          exwb_d = bundle_q;
          if (load_q) begin
            exwb_d.alu_result = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Abandoned access: flag it and stop the simulation downstream.
          exwb_d         = bundle_q;
          exwb_d.sim_end = 1'b1;
          err_d          = 1'b1;
          state_d        = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      bundle_q <= '0;
      exwb_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      exwb_q   <= exwb_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      load_q   <= load_d;
      store_q  <= store_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Request and strobes decode straight from the state register, so an
  // asynchronous reset drops mem_req without waiting for a clock edge.
  assign mem_ready             = (state_q == ST_IDLE);
  assign mem_req               = (state_q == ST_ACCESS);
  assign mem_we                = (state_q == ST_ACCESS) && store_q;
  assign mem_addr_o            = addr_q;
  assign mem_wdata             = wdata_q;
  assign exwb                  = exwb_q;
  assign can_writeback         = (state_q == ST_DONE);
  assign store_memstage_active = store_q && ((state_q == ST_ACCESS) || (state_q == ST_DONE));
  assign mem_error             = err_q;

endmodule
